gamma_stage: RTL and testbench

- Sequential gamma (non-linear S-box) layer of the Anubis round datapath.
- Accepts a 128-bit state matrix and substitutes all 16 bytes through the Anubis involutive S-box, LANES bytes per cycle.
- Presents the result to the tau/theta stage that follows it, holding the output until that stage takes it.
- Valid/ready handshake on both sides; trades area (LANES S-box instances) against latency.

---
 rtl/anubis_pkg.sv | 38 +++
 rtl/anubis_sbox.sv | 15 +
 rtl/gamma_stage.sv | 105 ++++++++++
 tb/tb_gamma_stage.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/anubis_pkg.sv
// anubis_pkg: shared Anubis constants, gamma state encoding and the involutive S-box table.
`default_nettype none

package anubis_pkg;

  localparam int BLOCK_W = 128;
  localparam int BYTE_W  = 8;
  localparam int NBYTES  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Involution: SBOX[SBOX[x]] == x for every x.
  localparam logic [7:0] SBOX [256] = '{
    8'hA7, 8'hD3, 8'hE6, 8'h71, 8'hD0, 8'hAC, 8'h4D, 8'h79, 8'h3A, 8'hC9, 8'h91, 8'hFC, 8'h1E, 8'h47, 8'h54, 8'hBD,
    8'h8C, 8'hA5, 8'h7A, 8'hFB, 8'h63, 8'hB8, 8'hDD, 8'hD4, 8'hE5, 8'hB3, 8'hC5, 8'hBE, 8'hA9, 8'h88, 8'h0C, 8'hA2,
    8'h39, 8'hDF, 8'h29, 8'hDA, 8'h2B, 8'hA8, 8'hCB, 8'h4C, 8'h4B, 8'h22, 8'hAA, 8'h24, 8'h41, 8'h70, 8'hA6, 8'hF9,
    8'h5A, 8'hE2, 8'hB0, 8'h36, 8'h7D, 8'hE4, 8'h33, 8'hFF, 8'h60, 8'h20, 8'h08, 8'h8B, 8'h5E, 8'hAB, 8'h7F, 8'h78,
    8'h7C, 8'h2C, 8'h57, 8'hD2, 8'hDC, 8'h6D, 8'h7E, 8'h0D, 8'h53, 8'h94, 8'hC3, 8'h28, 8'h27, 8'h06, 8'h5F, 8'hAD,
    8'h67, 8'h5C, 8'h55, 8'h48, 8'h0E, 8'h52, 8'hEA, 8'h42, 8'h5B, 8'h5D, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3C, 8'h4E,
    8'h38, 8'h8A, 8'h72, 8'h14, 8'hE7, 8'hC6, 8'hDE, 8'h50, 8'h8E, 8'h92, 8'hD1, 8'h77, 8'h93, 8'h45, 8'h9A, 8'hCE,
    8'h2D, 8'h03, 8'h62, 8'hB6, 8'hB9, 8'hBF, 8'h96, 8'h6B, 8'h3F, 8'h07, 8'h12, 8'hAE, 8'h40, 8'h34, 8'h46, 8'h3E,
    8'hDB, 8'hCF, 8'hEC, 8'hCC, 8'hC1, 8'hA1, 8'hC0, 8'hD6, 8'h1D, 8'hF4, 8'h61, 8'h3B, 8'h10, 8'hD8, 8'h68, 8'hA0,
    8'hB1, 8'h0A, 8'h69, 8'h6C, 8'h49, 8'hFA, 8'h76, 8'hC4, 8'h9E, 8'h9B, 8'h6E, 8'h99, 8'hC2, 8'hB7, 8'h98, 8'hBC,
    8'h8F, 8'h85, 8'h1F, 8'hB4, 8'hF8, 8'h11, 8'h2E, 8'h00, 8'h25, 8'h1C, 8'h2A, 8'h3D, 8'h05, 8'h4F, 8'h7B, 8'hB2,
    8'h32, 8'h90, 8'hAF, 8'h19, 8'hA3, 8'hF7, 8'h73, 8'h9D, 8'h15, 8'h74, 8'hEE, 8'hCA, 8'h9F, 8'h0F, 8'h1B, 8'h75,
    8'h86, 8'h84, 8'h9C, 8'h4A, 8'h97, 8'h1A, 8'h65, 8'hF6, 8'hED, 8'h09, 8'hBB, 8'h26, 8'h83, 8'hEB, 8'h6F, 8'h81,
    8'h04, 8'h6A, 8'h43, 8'h01, 8'h17, 8'hE1, 8'h87, 8'hF5, 8'h8D, 8'hE3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
    8'hFE, 8'hD5, 8'h31, 8'hD9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hF2, 8'hF1, 8'h56, 8'hCD, 8'h82, 8'hC8, 8'hBA, 8'hF0,
    8'hEF, 8'hE9, 8'hE8, 8'hFD, 8'h89, 8'hD7, 8'hC7, 8'hB5, 8'hA4, 8'h2F, 8'h95, 8'h13, 8'h0B, 8'hF3, 8'hE0, 8'h37
  };

endpackage

`default_nettype wire

// File: rtl/anubis_sbox.sv
// anubis_sbox: combinational 8-bit Anubis S-box lookup.
`default_nettype none

module anubis_sbox
  import anubis_pkg::*;
(
  input  logic [BYTE_W-1:0] x,
  output logic [BYTE_W-1:0] y
);

  assign y = SBOX[x];

endmodule

`default_nettype wire

// File: rtl/gamma_stage.sv
// gamma_stage: sequential Anubis gamma layer, LANES bytes substituted per cycle, valid/ready on both sides.
`default_nettype none

module gamma_stage
  import anubis_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy
);

  localparam int BEATS = NBYTES / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [BLOCK_W-1:0] work;
  logic [BLOCK_W-1:0] sub_word;
  logic [BYTE_W-1:0]  sb_in  [LANES];
  logic [BYTE_W-1:0]  sb_out [LANES];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sb_in[l] = work[(int'(cnt) * LANES + l) * BYTE_W +: BYTE_W];
    anubis_sbox u_sbox (
      .x (sb_in[l]),
      .y (sb_out[l])
    );
  end

  always_comb begin
    sub_word = work;
    for (int l = 0; l < LANES; l++) begin
      sub_word[(int'(cnt) * LANES + l) * BYTE_W +: BYTE_W] = sb_out[l];
    end
  end

  // A cycle carrying clear never reports ready, so upstream sees the dropped transfer.
  assign in_ready = !clear && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign busy     = (state == SUB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            cnt   <= '0;
            state <= SUB;
          end
        end
        SUB: begin
          work <= sub_word;
          if (cnt == LAST) begin
            out_data  <= sub_word;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work  <= in_data;
              cnt   <= '0;
              state <= SUB;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gamma_stage.sv
// tb_gamma_stage: scoreboard bench for gamma_stage against an independent byte-table model.
`default_nettype none

module tb_gamma_stage;

  localparam int LANES = 4;
  localparam int BEATS = 16 / LANES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         busy;

  logic [3:0]        sw_in_valid = '0;
  logic [3:0]        sw_in_ready;
  logic [3:0]        sw_out_valid;
  logic [3:0]        sw_busy;
  logic [3:0][127:0] sw_out_data;
  logic [127:0]      sw_data = '0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rnd_ready = 1'b0;

  logic [127:0] exp_q [$];
  int           acc_q [$];
  logic [127:0] last_out = '0;
  logic [127:0] held = '0;
  bit           hold_pending = 1'b0;
  bit           prev_valid = 1'b0;

  byte unsigned SB [256] = '{
    8'hA7, 8'hD3, 8'hE6, 8'h71, 8'hD0, 8'hAC, 8'h4D, 8'h79, 8'h3A, 8'hC9, 8'h91, 8'hFC, 8'h1E, 8'h47, 8'h54, 8'hBD,
    8'h8C, 8'hA5, 8'h7A, 8'hFB, 8'h63, 8'hB8, 8'hDD, 8'hD4, 8'hE5, 8'hB3, 8'hC5, 8'hBE, 8'hA9, 8'h88, 8'h0C, 8'hA2,
    8'h39, 8'hDF, 8'h29, 8'hDA, 8'h2B, 8'hA8, 8'hCB, 8'h4C, 8'h4B, 8'h22, 8'hAA, 8'h24, 8'h41, 8'h70, 8'hA6, 8'hF9,
    8'h5A, 8'hE2, 8'hB0, 8'h36, 8'h7D, 8'hE4, 8'h33, 8'hFF, 8'h60, 8'h20, 8'h08, 8'h8B, 8'h5E, 8'hAB, 8'h7F, 8'h78,
    8'h7C, 8'h2C, 8'h57, 8'hD2, 8'hDC, 8'h6D, 8'h7E, 8'h0D, 8'h53, 8'h94, 8'hC3, 8'h28, 8'h27, 8'h06, 8'h5F, 8'hAD,
    8'h67, 8'h5C, 8'h55, 8'h48, 8'h0E, 8'h52, 8'hEA, 8'h42, 8'h5B, 8'h5D, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3C, 8'h4E,
    8'h38, 8'h8A, 8'h72, 8'h14, 8'hE7, 8'hC6, 8'hDE, 8'h50, 8'h8E, 8'h92, 8'hD1, 8'h77, 8'h93, 8'h45, 8'h9A, 8'hCE,
    8'h2D, 8'h03, 8'h62, 8'hB6, 8'hB9, 8'hBF, 8'h96, 8'h6B, 8'h3F, 8'h07, 8'h12, 8'hAE, 8'h40, 8'h34, 8'h46, 8'h3E,
    8'hDB, 8'hCF, 8'hEC, 8'hCC, 8'hC1, 8'hA1, 8'hC0, 8'hD6, 8'h1D, 8'hF4, 8'h61, 8'h3B, 8'h10, 8'hD8, 8'h68, 8'hA0,
    8'hB1, 8'h0A, 8'h69, 8'h6C, 8'h49, 8'hFA, 8'h76, 8'hC4, 8'h9E, 8'h9B, 8'h6E, 8'h99, 8'hC2, 8'hB7, 8'h98, 8'hBC,
    8'h8F, 8'h85, 8'h1F, 8'hB4, 8'hF8, 8'h11, 8'h2E, 8'h00, 8'h25, 8'h1C, 8'h2A, 8'h3D, 8'h05, 8'h4F, 8'h7B, 8'hB2,
    8'h32, 8'h90, 8'hAF, 8'h19, 8'hA3, 8'hF7, 8'h73, 8'h9D, 8'h15, 8'h74, 8'hEE, 8'hCA, 8'h9F, 8'h0F, 8'h1B, 8'h75,
    8'h86, 8'h84, 8'h9C, 8'h4A, 8'h97, 8'h1A, 8'h65, 8'hF6, 8'hED, 8'h09, 8'hBB, 8'h26, 8'h83, 8'hEB, 8'h6F, 8'h81,
    8'h04, 8'h6A, 8'h43, 8'h01, 8'h17, 8'hE1, 8'h87, 8'hF5, 8'h8D, 8'hE3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
    8'hFE, 8'hD5, 8'h31, 8'hD9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hF2, 8'hF1, 8'h56, 8'hCD, 8'h82, 8'hC8, 8'hBA, 8'hF0,
    8'hEF, 8'hE9, 8'hE8, 8'hFD, 8'h89, 8'hD7, 8'hC7, 8'hB5, 8'hA4, 8'h2F, 8'h95, 8'h13, 8'h0B, 8'hF3, 8'hE0, 8'h37
  };

  gamma_stage #(.LANES(LANES)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sweep
    gamma_stage #(.LANES((k < 2) ? (1 << k) : (1 << (k + 1)))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (1'b0),
      .in_valid  (sw_in_valid[k]),
      .in_ready  (sw_in_ready[k]),
      .in_data   (sw_data),
      .out_valid (sw_out_valid[k]),
      .out_ready (1'b1),
      .out_data  (sw_out_data[k]),
      .busy      (sw_busy[k])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [127:0] gamma_ref(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = SB[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake, also checks latency and hold stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !prev_valid) begin
        if (acc_q.size() == 0) check("unexpected_valid", 128'(out_valid), 128'(0));
        else check("latency", 128'(cyc - acc_q.pop_front()), 128'(BEATS));
      end
      if (out_valid && hold_pending) check("hold_stable", out_data, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", out_data, 128'(0));
        else check("data", out_data, exp_q.pop_front());
        last_out     = out_data;
        hold_pending = 1'b0;
      end else if (out_valid) begin
        held         = out_data;
        hold_pending = 1'b1;
      end else begin
        hold_pending = 1'b0;
      end
      prev_valid = out_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic flush();
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic send(input logic [127:0] d, input logic [127:0] exp);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready && n < 100) begin
      tick();
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 128'(in_ready), 128'(1));
    end else begin
      exp_q.push_back(exp);
      acc_q.push_back(cyc + 1);
      tick();
    end
    in_valid = 1'b0;
    in_data  = rnd128();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 128'(exp_q.size()), 128'(0));
      flush();
    end
  endtask

  initial begin
    logic [127:0] d;
    logic [127:0] snap;
    int n;
    int lanes;

    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_out_data", out_data, 128'(0));
    check("reset_in_ready", 128'(in_ready), 128'(1));
    check("reset_busy", 128'(busy), 128'(0));
    #10 rst_n = 1'b1;
    tick();

    // Single all-zero block.
    out_ready = 1'b1;
    send('0, {16{8'hA7}});
    drain();

    // Backpressure, then simultaneous consume and accept.
    out_ready = 1'b0;
    send('0, {16{8'hA7}});
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    check("bp_valid", 128'(out_valid), 128'(1));
    snap = out_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_out_data", out_data, snap);
    end
    out_ready = 1'b1;
    send({16{8'h01}}, {16{8'hD3}});
    drain();

    // Abort on the second SUB beat.
    d = rnd128();
    send(d, gamma_ref(d));
    tick();
    clear = 1'b1;
    flush();
    tick();
    clear = 1'b0;
    #1;
    check("clear_busy", 128'(busy), 128'(0));
    check("clear_in_ready", 128'(in_ready), 128'(1));
    check("clear_out_valid", 128'(out_valid), 128'(0));
    for (int i = 0; i < 6; i++) tick();
    check("clear_no_valid", 128'(out_valid), 128'(0));
    d = rnd128();
    send(d, gamma_ref(d));
    drain();

    // Random blocks with randomized backpressure, each fed back to check the involution.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      d = rnd128();
      send(d, gamma_ref(d));
      drain();
      send(last_out, d);
      drain();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    // Asynchronous reset mid-block.
    d = rnd128();
    send(d, gamma_ref(d));
    #2 rst_n = 1'b0;
    #1;
    flush();
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_out_data", out_data, 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_busy", 128'(busy), 128'(0));
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Lane-count sweep on the extra instances.
    for (int k = 0; k < 4; k++) begin
      lanes = (k < 2) ? (1 << k) : (1 << (k + 1));
      d = rnd128();
      sw_data = d;
      sw_in_valid[k] = 1'b1;
      #1;
      check("sweep_in_ready", 128'(sw_in_ready[k]), 128'(1));
      tick();
      sw_in_valid[k] = 1'b0;
      sw_data = rnd128();
      n = 0;
      while (!sw_out_valid[k] && n < 40) begin tick(); n++; end
      check($sformatf("sweep_latency_l%0d", lanes), 128'(n), 128'(16 / lanes));
      check($sformatf("sweep_data_l%0d", lanes), sw_out_data[k], gamma_ref(d));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
